// File: rtl/mac_v4_pkg.sv
// Shared widths and types for the four-element unsigned MAC.
package mac_v4_pkg;

  localparam int unsigned IN_W      = 4;
  localparam int unsigned PROD_W    = 2 * IN_W;
  localparam int unsigned OUT_W     = 10;
  localparam int unsigned GROUP_LEN = 4;
  localparam int unsigned CNT_W     = 2;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [IN_W-1:0]   opnd_t;
  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [OUT_W-1:0]  acc_t;

  localparam cnt_t LAST_IDX = cnt_t'(GROUP_LEN - 1);

endpackage : mac_v4_pkg

// File: rtl/mac_v4_if.sv
// Operand/result bundle between the operand sequencer and the MAC.
interface mac_v4_if;
  import mac_v4_pkg::*;

  logic  in_valid;
  opnd_t in1_IFM;
  opnd_t in2_IFM;
  logic  out_valid;
  acc_t  out;

  // Sequencer / result-consumer side
  modport master (
    output in_valid, in1_IFM, in2_IFM,
    input  out_valid, out
  );

  // MAC side
  modport slave (
    input  in_valid, in1_IFM, in2_IFM,
    output out_valid, out
  );

endinterface : mac_v4_if

// File: rtl/mac_v4_mul_stage.sv
// Stage 1: registered unsigned 4x4 multiply with valid and last-element flags.
module mac_v4_mul_stage
  import mac_v4_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  input  opnd_t a,
  input  opnd_t b,
  input  logic  last_in,
  output logic  p_valid,
  output prod_t prod,
  output logic  p_last
);

  // Capture product and flags; operands are ignored when not valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      prod    <= '0;
      p_last  <= 1'b0;
    end else begin
      p_valid <= in_valid;
      prod    <= in_valid ? prod_t'(a) * prod_t'(b) : '0;
      p_last  <= in_valid & last_in;
    end
  end

endmodule : mac_v4_mul_stage

// File: rtl/mac_v4.sv
// Four-element unsigned dot-product unit: counter, accumulator, output register.
module mac_v4
  import mac_v4_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  mac_v4_if.slave bus
);

  cnt_t  cnt;
  logic  last_in;
  logic  s1_valid;
  prod_t s1_prod;
  logic  s1_last;
  acc_t  acc;
  acc_t  sum;
  acc_t  out_r;
  logic  out_valid_r;

  assign last_in = (cnt == LAST_IDX);

  // Element counter advances only on sampled pairs and wraps at group end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (bus.in_valid) begin
      cnt <= last_in ? '0 : cnt + cnt_t'(1);
    end
  end

  mac_v4_mul_stage u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.in_valid),
    .a        (bus.in1_IFM),
    .b        (bus.in2_IFM),
    .last_in  (last_in),
    .p_valid  (s1_valid),
    .prod     (s1_prod),
    .p_last   (s1_last)
  );

  // Running sum including the product currently leaving stage 1
  always_comb begin
    sum = acc + acc_t'(s1_prod);
  end

  // Stage 2: accumulate, emit on last element; acc is zeroed at group end so
  // the first element of the next group effectively loads its product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      out_r       <= '0;
      out_valid_r <= 1'b0;
    end else begin
      out_r       <= '0;
      out_valid_r <= 1'b0;
      if (s1_valid) begin
        if (s1_last) begin
          acc         <= '0;
          out_r       <= sum;
          out_valid_r <= 1'b1;
        end else begin
          acc <= sum;
        end
      end
    end
  end

  assign bus.out       = out_r;
  assign bus.out_valid = out_valid_r;

endmodule : mac_v4

// File: tb/tb_mac_v4.sv
// Directed self-checking bench for mac_v4.
module tb_mac_v4;

  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_fail;

  mac_v4_if bus ();

  mac_v4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // At the falling edge: check outputs left by the previous rising edge, then drive the next pair
  task automatic step(input string tag, input logic v, input int unsigned a, input int unsigned b,
                      input int unsigned exp_v, input int unsigned exp_o);
    @(negedge clk);
    check_eq({tag, ".out_valid"}, int'(bus.out_valid), exp_v);
    check_eq({tag, ".out"}, int'(bus.out), exp_o);
    bus.in_valid = v;
    bus.in1_IFM  = 4'(a);
    bus.in2_IFM  = 4'(b);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in1_IFM  = '0;
    bus.in2_IFM  = '0;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) step("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step("idle", 0, 0, 0, 0, 0);

    // Basic group: 5+12+21+32 = 70
    step("basic", 1, 1, 5, 0, 0);
    step("basic", 1, 2, 6, 0, 0);
    step("basic", 1, 3, 7, 0, 0);
    step("basic", 1, 4, 8, 0, 0);
    step("basic", 0, 0, 0, 0, 0);
    step("basic", 0, 0, 0, 1, 70);
    step("basic", 0, 0, 0, 0, 0);

    // Maximum: 4*225 = 900
    for (int i = 0; i < 4; i++) step("max", 1, 15, 15, 0, 0);
    step("max", 0, 0, 0, 0, 0);
    step("max", 0, 0, 0, 1, 900);
    step("max", 0, 0, 0, 0, 0);

    // Zero result still strobes valid
    for (int i = 0; i < 4; i++) step("zero", 1, 0, 9, 0, 0);
    step("zero", 0, 0, 0, 0, 0);
    step("zero", 0, 0, 0, 1, 0);
    step("zero", 0, 0, 0, 0, 0);

    // Gapped: junk operands while invalid must be ignored; 4*9 = 36
    step("gap", 1, 3, 3, 0, 0);
    for (int i = 0; i < 5; i++) step("gap", 0, 15, 15, 0, 0);
    for (int i = 0; i < 3; i++) step("gap", 1, 3, 3, 0, 0);
    step("gap", 0, 0, 0, 0, 0);
    step("gap", 0, 0, 0, 1, 36);
    step("gap", 0, 0, 0, 0, 0);

    // Back-to-back: 16 then 60, four cycles apart
    for (int i = 0; i < 4; i++) step("b2b", 1, 2, 2, 0, 0);
    step("b2b", 1, 15, 1, 0, 0);
    step("b2b", 1, 15, 1, 1, 16);
    step("b2b", 1, 15, 1, 0, 0);
    step("b2b", 1, 15, 1, 0, 0);
    step("b2b", 0, 0, 0, 0, 0);
    step("b2b", 0, 0, 0, 1, 60);
    step("b2b", 0, 0, 0, 0, 0);

    // Reset mid-group: aborted partial sum never surfaces; 4*1 = 4
    step("abort", 1, 15, 15, 0, 0);
    step("abort", 1, 15, 15, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_eq("abort.rst_out_valid", int'(bus.out_valid), 0);
    check_eq("abort.rst_out", int'(bus.out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step("abort", 1, 1, 1, 0, 0);
    step("abort", 0, 0, 0, 0, 0);
    step("abort", 0, 0, 0, 1, 4);
    for (int i = 0; i < 3; i++) step("abort", 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mac_v4
